// File: rtl/apu_i2s_out.sv
// APU audio back-end: 32-sample box decimation of the triangle channel into
// signed 16-bit PCM, serialized as a stereo I2S stream with locally divided clocks.
module apu_i2s_out #(
  parameter int BCLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        cpu_clk_en,
  input  logic [3:0]  triangle_wave,
  input  logic        mute,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [8:0]       acc_r;
  logic [4:0]       wcnt_r;
  logic [DIV_W-1:0] div_r;
  logic [5:0]       slot_r;
  logic [15:0]      shadow_r;

  logic [8:0]  sum_s;
  logic [15:0] pcm_s;
  logic        div_tc_s;
  logic        bclk_fall_s;
  logic [5:0]  slot_next_s;
  logic        sdata_next_s;

  // Bit k of a channel slot carries word[16-k] for k in 1..16 (one-bit I2S delay).
  function automatic logic sdata_bit(input logic [15:0] word, input logic [4:0] k);
    logic [3:0] idx;
    begin
      idx = 4'd0 - k[3:0];
      if ((k >= 5'd1) && (k <= 5'd16)) begin
        sdata_bit = word[idx];
      end else begin
        sdata_bit = 1'b0;
      end
    end
  endfunction

  // Window sum, PCM conversion and next-slot serial bit.
  always_comb begin
    sum_s        = acc_r + {5'd0, triangle_wave};
    pcm_s        = {1'b0, sum_s, 6'd0} - 16'd15360;
    div_tc_s     = (div_r == DIV_LAST);
    bclk_fall_s  = div_tc_s & i2s_bclk;
    slot_next_s  = slot_r + 6'd1;
    sdata_next_s = sdata_bit(shadow_r, slot_next_s[4:0]);
  end

  // Box-average accumulator; the 32nd enable of a window publishes the sample.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc_r        <= 9'd0;
      wcnt_r       <= 5'd0;
      sample_out   <= 16'd0;
      sample_valid <= 1'b0;
    end else if (cpu_clk_en) begin
      if (wcnt_r == 5'd31) begin
        acc_r        <= 9'd0;
        wcnt_r       <= 5'd0;
        sample_out   <= mute ? 16'd0 : pcm_s;
        sample_valid <= 1'b1;
      end else begin
        acc_r        <= sum_s;
        wcnt_r       <= wcnt_r + 5'd1;
        sample_valid <= 1'b0;
      end
    end else begin
      sample_valid <= 1'b0;
    end
  end

  // Bit-clock divider: toggle bclk every BCLK_DIV system clocks.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_r    <= '0;
      i2s_bclk <= 1'b0;
    end else if (div_tc_s) begin
      div_r    <= '0;
      i2s_bclk <= ~i2s_bclk;
    end else begin
      div_r    <= div_r + DIV_W'(1);
      i2s_bclk <= i2s_bclk;
    end
  end

  // Slot/word-select/data advance on falling bclk; frame wrap latches the shadow.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      slot_r    <= 6'd0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      shadow_r  <= 16'd0;
    end else if (bclk_fall_s) begin
      slot_r    <= slot_next_s;
      i2s_lrck  <= slot_next_s[5];
      i2s_sdata <= sdata_next_s;
      if (slot_r == 6'd63) begin
        shadow_r <= sample_out;
      end else begin
        shadow_r <= shadow_r;
      end
    end else begin
      slot_r    <= slot_r;
      i2s_lrck  <= i2s_lrck;
      i2s_sdata <= i2s_sdata;
      shadow_r  <= shadow_r;
    end
  end

endmodule

// File: tb/tb_apu_i2s_out.sv
// Randomized bench for apu_i2s_out with a time-indexed reference model of the
// decimator and the I2S frame (BCLK_DIV = 2).
module tb_apu_i2s_out;

  localparam int D     = 2;
  localparam int FRAME = 128 * D;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        cpu_clk_en = 1'b0;
  logic [3:0]  triangle_wave = 4'd0;
  logic        mute = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;

  apu_i2s_out #(.BCLK_DIV(D)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .cpu_clk_en   (cpu_clk_en),
    .triangle_wave(triangle_wave),
    .mute         (mute),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: n = clk edges since reset release.
  int          n;
  int          win_sum;
  int          win_cnt;
  logic [15:0] m_sample;
  logic        m_valid;
  logic [15:0] m_shadow;

  function automatic logic e_bclk(input int nn);
    return ((nn / D) % 2) == 1;
  endfunction

  function automatic logic e_lrck(input int nn);
    return ((nn / (2 * D)) % 64) >= 32;
  endfunction

  function automatic logic e_sdata(input int nn, input logic [15:0] sh);
    int k;
    k = (nn / (2 * D)) % 32;
    if (k >= 1 && k <= 16) return sh[16 - k];
    else return 1'b0;
  endfunction

  task automatic model_reset();
    n = 0; win_sum = 0; win_cnt = 0;
    m_sample = 16'd0; m_valid = 1'b0; m_shadow = 16'd0;
  endtask

  task automatic tick(input logic en, input logic [3:0] tw, input logic mu);
    logic [15:0] prev;
    cpu_clk_en = en; triangle_wave = tw; mute = mu;
    @(posedge clk); #1;
    prev = m_sample;
    m_valid = 1'b0;
    if (en) begin
      win_sum += int'(tw);
      win_cnt++;
      if (win_cnt == 32) begin
        m_sample = mu ? 16'd0 : 16'(win_sum * 64 - 15360);
        m_valid  = 1'b1;
        win_sum  = 0;
        win_cnt  = 0;
      end
    end
    n++;
    if (n % FRAME == 0) m_shadow = prev;
  endtask

  task automatic idle();
    tick(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    model_reset();
  endtask

  // Record one frame of bits sampled at rising bclk; starts on a frame boundary.
  task automatic capture_frame(output logic [15:0] lw, output logic [15:0] rw,
                               output logic extra, output int high_cnt);
    logic pb;
    int   r;
    pb = i2s_bclk; r = 0; lw = 16'd0; rw = 16'd0; extra = 1'b0; high_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      idle();
      if (i2s_lrck) high_cnt++;
      if (!pb && i2s_bclk) begin
        if (r >= 1 && r <= 16) lw[16 - r] = i2s_sdata;
        else if (r >= 33 && r <= 48) rw[48 - r] = i2s_sdata;
        else extra = extra | i2s_sdata;
        r++;
      end
      pb = i2s_bclk;
    end
  endtask

  task automatic align_frame();
    for (int i = 0; i < FRAME && (n % FRAME) != 0; i++) idle();
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if ({sample_out, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected 00000",
               {sample_out, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata});
    end
    release_reset();
    for (int i = 1; i <= 4 * D; i++) begin
      idle();
      vectors++;
      if (i2s_bclk !== (((i / D) % 2) == 1)) begin
        miscompares++;
        $display("FAIL bclk_start: clk %0d got %b expected %b", i, i2s_bclk, ((i / D) % 2) == 1);
      end
      vectors++;
      if (i2s_lrck !== 1'b0) begin
        miscompares++;
        $display("FAIL lrck_start: clk %0d got %b expected 0", i, i2s_lrck);
      end
    end
  endtask

  // mode 0: constant 15, 1: constant 0, 2: alternating 7/8
  task automatic test_window(input string name, input int mode, input logic final_mute,
                             input logic [15:0] exp_pcm);
    int pulses;
    logic [3:0] lvl;
    pulses = 0;
    for (int e = 0; e < 32; e++) begin
      repeat ($urandom_range(0, 2)) begin
        idle();
        if (sample_valid) pulses++;
      end
      case (mode)
        0: lvl = 4'd15;
        1: lvl = 4'd0;
        default: lvl = (e % 2 == 0) ? 4'd7 : 4'd8;
      endcase
      tick(1'b1, lvl, (e == 31) ? final_mute : 1'($urandom_range(0, 1)));
      if (sample_valid) pulses++;
    end
    vectors++;
    if (sample_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid: got %b expected 1", name, sample_valid);
    end
    vectors++;
    if (sample_out !== exp_pcm) begin
      miscompares++;
      $display("FAIL %s_pcm: got %h expected %h", name, sample_out, exp_pcm);
    end
    idle();
    vectors++;
    if (sample_valid !== 1'b0 || sample_out !== exp_pcm) begin
      miscompares++;
      $display("FAIL %s_hold: got valid %b pcm %h expected 0 %h", name, sample_valid, sample_out, exp_pcm);
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL %s_pulses: got %0d expected 1", name, pulses);
    end
  endtask

  task automatic test_i2s_bits();
    logic [15:0] lw, rw;
    logic        extra;
    int          hc;
    align_frame();
    capture_frame(lw, rw, extra, hc);
    vectors++;
    if (lw !== 16'h3C00) begin
      miscompares++;
      $display("FAIL i2s_left: got %h expected 3c00", lw);
    end
    vectors++;
    if (rw !== 16'h3C00) begin
      miscompares++;
      $display("FAIL i2s_right: got %h expected 3c00", rw);
    end
    vectors++;
    if (extra !== 1'b0) begin
      miscompares++;
      $display("FAIL i2s_pad: got %b expected 0", extra);
    end
    vectors++;
    if (hc !== 64 * D) begin
      miscompares++;
      $display("FAIL lrck_high: got %0d clk expected %0d", hc, 64 * D);
    end
  endtask

  task automatic test_wrap_collision();
    logic [15:0] lw, rw;
    logic        extra;
    int          hc;
    for (int e = 0; e < 31; e++) tick(1'b1, 4'd0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < FRAME && (n % FRAME) != FRAME - 1; i++) idle();
    tick(1'b1, 4'd0, 1'b0);
    vectors++;
    if (sample_valid !== 1'b1 || sample_out !== 16'hC400 || (n % FRAME) !== 0) begin
      miscompares++;
      $display("FAIL collide_setup: got valid %b pcm %h phase %0d expected 1 c400 0",
               sample_valid, sample_out, n % FRAME);
    end
    capture_frame(lw, rw, extra, hc);
    vectors++;
    if (lw !== 16'h3C00 || rw !== 16'h3C00) begin
      miscompares++;
      $display("FAIL collide_old_frame: got %h/%h expected 3c00/3c00", lw, rw);
    end
    capture_frame(lw, rw, extra, hc);
    vectors++;
    if (lw !== 16'hC400 || rw !== 16'hC400 || extra !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_new_frame: got %h/%h pad %b expected c400/c400 0", lw, rw, extra);
    end
  endtask

  task automatic test_random_stream(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
      vectors++;
      if (sample_out !== m_sample || sample_valid !== m_valid) begin
        miscompares++;
        $display("FAIL %s_pcm: clk %0d got %h/%b expected %h/%b", name, n, sample_out, sample_valid, m_sample, m_valid);
      end
      vectors++;
      if (i2s_bclk !== e_bclk(n) || i2s_lrck !== e_lrck(n)) begin
        miscompares++;
        $display("FAIL %s_clocks: clk %0d got %b%b expected %b%b", name, n, i2s_bclk, i2s_lrck, e_bclk(n), e_lrck(n));
      end
      vectors++;
      if (i2s_sdata !== e_sdata(n, m_shadow)) begin
        miscompares++;
        $display("FAIL %s_sdata: clk %0d got %b expected %b", name, n, i2s_sdata, e_sdata(n, m_shadow));
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 2 * FRAME && (n % FRAME) != (FRAME * 3 / 4); i++)
      tick(1'b1, 4'($urandom_range(8, 15)), 1'b0);
    vectors++;
    if (i2s_lrck !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_setup: got lrck %b expected 1", i2s_lrck);
    end
    cpu_clk_en = 1'b0;
    rst_l = 1'b0;
    #1;
    vectors++;
    if ({sample_out, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata} !== 20'd0) begin
      miscompares++;
      $display("FAIL midframe_reset: got %h expected 00000",
               {sample_out, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata});
    end
    release_reset();
    idle();
    vectors++;
    if (i2s_lrck !== 1'b0 || i2s_bclk !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_restart: got lrck %b bclk %b expected 0 0", i2s_lrck, i2s_bclk);
    end
    test_random_stream("post_reset", 2 * FRAME);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_window("win_15", 0, 1'b0, 16'h3C00);
    test_window("win_0", 1, 1'b0, 16'hC400);
    test_window("win_alt", 2, 1'b0, 16'h0000);
    test_window("win_mute", 0, 1'b1, 16'h0000);
    test_window("win_15b", 0, 1'b0, 16'h3C00);
    test_i2s_bits();
    test_wrap_collision();
    test_random_stream("stream", 3000);
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
